// File: rtl/mem_stage.sv
// Memory-access stage: data-memory req/ack handshake, upstream stall, and the MEM/WB register.
// Build with MEM_TIMEOUT_EN defined to abort accesses that stay unacknowledged for TIMEOUT_CYCLES.
module mem_stage #(
    parameter int DATA_BIT_WIDTH = 32,
    parameter int ADDR_BITS      = 14,
    parameter int RESET_VALUE    = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_BIT_WIDTH-1:0] pcIncrementedIn,
    input  logic [DATA_BIT_WIDTH-1:0] aluResultIn,
    input  logic [DATA_BIT_WIDTH-1:0] condRegResultIn,
    input  logic [DATA_BIT_WIDTH-1:0] regData2In,
    input  logic [3:0]                regWriteNoIn,
    input  logic                      wrMemIn,
    input  logic                      wrRegIn,
    input  logic [1:0]                dstRegMuxSelIn,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_BITS-1:0]      mem_addr,
    output logic [DATA_BIT_WIDTH-1:0] mem_wdata,
    input  logic [DATA_BIT_WIDTH-1:0] mem_rdata,
    input  logic                      mem_ack,
    output logic                      stall,
    output logic [DATA_BIT_WIDTH-1:0] wbDataOut,
    output logic [3:0]                wbRegNoOut,
    output logic                      wbWrRegOut,
    output logic                      mem_err
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [DATA_BIT_WIDTH-1:0] RST_DATA = DATA_BIT_WIDTH'(RESET_VALUE);
    localparam logic [ADDR_BITS-1:0]      RST_ADDR = ADDR_BITS'(RESET_VALUE);
    localparam logic [3:0]                RST_REG  = 4'(RESET_VALUE);
    localparam logic                      RST_WR   = 1'(RESET_VALUE);

    state_t                    state_q, state_d;
    logic                      mem_req_q, mem_req_d;
    logic                      mem_we_q, mem_we_d;
    logic [ADDR_BITS-1:0]      mem_addr_q, mem_addr_d;
    logic [DATA_BIT_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_BIT_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_BIT_WIDTH-1:0] wb_data_q, wb_data_d;
    logic [3:0]                wb_reg_no_q, wb_reg_no_d;
    logic                      wb_wr_reg_q, wb_wr_reg_d;
    logic                      mem_err_q, mem_err_d;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    logic                      is_store, is_load, is_access, misaligned;
    logic [DATA_BIT_WIDTH-1:0] sel_data;

    always_comb begin
        is_store   = wrMemIn;
        is_load    = wrRegIn && (dstRegMuxSelIn == 2'b01) && !wrMemIn;
        is_access  = is_store || is_load;
        misaligned = |aluResultIn[1:0];

        case (dstRegMuxSelIn)
            2'b00:   sel_data = aluResultIn;
            2'b01:   sel_data = rdata_q;
            2'b10:   sel_data = pcIncrementedIn;
            default: sel_data = condRegResultIn;
        endcase

        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        wb_data_d   = wb_data_q;
        wb_reg_no_d = wb_reg_no_q;
        wb_wr_reg_d = 1'b0;
        mem_err_d   = 1'b0;
        stall       = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (is_access) begin
                    if (misaligned) begin
                        mem_err_d = 1'b1;
                    end else begin
                        stall       = 1'b1;
                        state_d     = WAIT;
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store;
                        mem_addr_d  = aluResultIn[ADDR_BITS+1:2];
                        mem_wdata_d = regData2In;
`ifdef MEM_TIMEOUT_EN
                        cnt_d       = '0;
`endif
                    end
                end else begin
                    wb_data_d   = sel_data;
                    wb_reg_no_d = regWriteNoIn;
                    wb_wr_reg_d = wrRegIn;
                end
            end
            WAIT: begin
                stall = 1'b1;
                // An ack arriving in the timeout cycle still completes normally.
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    rdata_d   = mem_rdata;
                    state_d   = DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    mem_req_d = 1'b0;
                    rdata_d   = DATA_BIT_WIDTH'(32'hDEADBEEF);
                    mem_err_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                wb_data_d   = is_load ? rdata_q : sel_data;
                wb_reg_no_d = regWriteNoIn;
                wb_wr_reg_d = wrRegIn && !wrMemIn;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= RST_ADDR;
            mem_wdata_q <= RST_DATA;
            rdata_q     <= '0;
            wb_data_q   <= RST_DATA;
            wb_reg_no_q <= RST_REG;
            wb_wr_reg_q <= RST_WR;
            mem_err_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            wb_data_q   <= wb_data_d;
            wb_reg_no_q <= wb_reg_no_d;
            wb_wr_reg_q <= wb_wr_reg_d;
            mem_err_q   <= mem_err_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign wbDataOut  = wb_data_q;
    assign wbRegNoOut = wb_reg_no_q;
    assign wbWrRegOut = wb_wr_reg_q;
    assign mem_err    = mem_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: randomized instruction stream against a word-level memory model.
// Timeout scenario is exercised only when MEM_TIMEOUT_EN is defined.
module tb_mem_stage;

    localparam int DW = 32;
    localparam int AW = 14;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] pcIncrementedIn, aluResultIn, condRegResultIn, regData2In;
    logic [3:0]    regWriteNoIn;
    logic          wrMemIn, wrRegIn;
    logic [1:0]    dstRegMuxSelIn;
    logic          mem_req, mem_we, mem_ack, stall, wbWrRegOut, mem_err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata, wbDataOut;
    logic [3:0]    wbRegNoOut;

    mem_stage #(
        .DATA_BIT_WIDTH(DW),
        .ADDR_BITS(AW),
        .RESET_VALUE(0),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .pcIncrementedIn(pcIncrementedIn), .aluResultIn(aluResultIn),
        .condRegResultIn(condRegResultIn), .regData2In(regData2In),
        .regWriteNoIn(regWriteNoIn), .wrMemIn(wrMemIn), .wrRegIn(wrRegIn),
        .dstRegMuxSelIn(dstRegMuxSelIn),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
        .wbDataOut(wbDataOut), .wbRegNoOut(wbRegNoOut), .wbWrRegOut(wbWrRegOut),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata;} req_t;
    typedef struct packed {logic [DW-1:0] data; logic [3:0] rno;} wb_t;

    req_t        req_q[$];
    wb_t         wb_q[$];
    logic [31:0] mem_model [16];
    int          next_lat = 0;
    int          err_exp  = 0;
    int          err_seen = 0;
    int          passed   = 0;
    int          total    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    // Memory responder: acks the held request after next_lat extra WAIT cycles; ack noise while idle.
    initial begin
        int   cnt;
        bit   active;
        req_t cur;
        mem_ack = 1'b0; mem_rdata = '0; active = 0; cnt = 0; cur = '0;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                if (!active) begin
                    active = 1; cnt = 0;
                    check("req_expected", 64'(req_q.size() > 0), 64'd1);
                    if (req_q.size() > 0) cur = req_q.pop_front();
                end
                check("req_fields", {mem_we, mem_addr, mem_wdata}, cur);
                if (cnt == next_lat) begin
                    mem_ack = 1'b1; mem_rdata = mem_model[mem_addr[3:0]];
                end else begin
                    mem_ack = 1'b0; mem_rdata = $urandom;
                end
                cnt++;
            end else begin
                active = 0;
                mem_ack = ($urandom % 4 == 0);
                mem_rdata = $urandom;
            end
        end
    end

    // Writeback monitor.
    initial begin
        wb_t e;
        forever begin
            @(negedge clk);
            if (mem_err === 1'b1) err_seen++;
            if (wbWrRegOut === 1'b1) begin
                if (wb_q.size() == 0) begin
                    total++;
                    $display("FAIL wb_unexpected: got reg %0d data %h, required no writeback", wbRegNoOut, wbDataOut);
                end else begin
                    e = wb_q.pop_front();
                    check("wb_data", wbDataOut, e.data);
                    check("wb_reg", wbRegNoOut, e.rno);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, passed %0d", passed);
        $display("%0d/%0d checks passed", passed, total + 1);
        $fatal(1, "watchdog");
    end

    task automatic set_idle();
        wrMemIn = 0; wrRegIn = 0; dstRegMuxSelIn = 0; regWriteNoIn = 0;
        aluResultIn = 0; pcIncrementedIn = 0; condRegResultIn = 0; regData2In = 0;
    endtask

    // Reference model works per instruction; then drives it and holds it while stall is high.
    task automatic issue(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] cond,
                         input logic [31:0] d2, input logic [3:0] rno, input logic wm,
                         input logic wr, input logic [1:0] sel, input int lat);
        logic ld, acc, mis, timed, s;
        logic [31:0] v;
        int exp_stall, cyc, n;
        req_t r;
        wb_t  w;
        ld  = wr && (sel == 2'd1) && !wm;
        acc = wm || ld;
        mis = (alu[1:0] != 2'd0);
        timed = 0;
`ifdef MEM_TIMEOUT_EN
        timed = (lat >= TO);
`endif
        exp_stall = 0;
        if (acc && mis) begin
            err_exp++;
        end else if (acc) begin
            r.we = wm; r.addr = alu[15:2]; r.wdata = d2;
            req_q.push_back(r);
            exp_stall = timed ? 1 + TO : lat + 2;
            if (timed) err_exp++;
            if (wm) mem_model[alu[5:2]] = d2;
            else begin
                w.data = timed ? 32'hDEADBEEF : mem_model[alu[5:2]];
                w.rno = rno;
                wb_q.push_back(w);
            end
        end else if (wr) begin
            case (sel)
                2'd0:    v = alu;
                2'd2:    v = pc;
                default: v = cond;
            endcase
            w.data = v; w.rno = rno;
            wb_q.push_back(w);
        end
        next_lat = lat;
        pcIncrementedIn = pc; aluResultIn = alu; condRegResultIn = cond; regData2In = d2;
        regWriteNoIn = rno; wrMemIn = wm; wrRegIn = wr; dstRegMuxSelIn = sel;
        cyc = 0; n = 0;
        do begin
            @(negedge clk); s = stall;
            @(posedge clk); #1;
            if (s) cyc++;
            n++;
        end while (s && n < 1000);
        check("stall_cycles", 64'(cyc), 64'(exp_stall));
    endtask

    initial begin
        logic [31:0] alu, hi;
        logic        wm, wr;
        logic [1:0]  sel;
        int          lat, widx, off;

        reset = 1'b1;
        set_idle();
        for (int i = 0; i < 16; i++) mem_model[i] = $urandom;
        mem_model[0] = 32'hCAFEF00D;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_err", mem_err, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_wb", {wbDataOut, wbRegNoOut, wbWrRegOut}, 0);
        check("rst_stall", stall, 0);
        reset = 1'b0;

        issue(32'h100, 32'h1234, 32'h77, 32'h0, 4'd5, 0, 1, 2'd0, 0);
        check("alu_wb_data", wbDataOut, 32'h1234);
        check("alu_wb_reg", wbRegNoOut, 5);
        check("alu_wb_wr", wbWrRegOut, 1);

        issue(32'h104, 32'h40, 32'h0, 32'h0, 4'd7, 0, 1, 2'd1, 2);
        check("load_addr", mem_addr, 14'h10);
        check("load_we", mem_we, 0);
        check("load_wb_data", wbDataOut, 32'hCAFEF00D);
        check("load_wb_wr", wbWrRegOut, 1);

        issue(32'h108, 32'h8, 32'h0, 32'hA5A5A5A5, 4'd3, 1, 1, 2'd0, 0);
        check("store_we", mem_we, 1);
        check("store_addr", mem_addr, 14'h2);
        check("store_wdata", mem_wdata, 32'hA5A5A5A5);
        check("store_wb_wr", wbWrRegOut, 0);

        issue(32'h10C, 32'h42, 32'h0, 32'h0, 4'd9, 0, 1, 2'd1, 0);
        check("mis_err", mem_err, 1);
        check("mis_req", mem_req, 0);
        check("mis_wb_wr", wbWrRegOut, 0);
        set_idle();
        @(posedge clk); #1;
        check("mis_err_pulse", mem_err, 0);

        // Reset while an access is outstanding.
        alu = 32'h44;
        req_q.push_back('{we: 1'b0, addr: alu[15:2], wdata: 32'h0});
        next_lat = 1000;
        aluResultIn = alu; wrRegIn = 1; dstRegMuxSelIn = 2'd1; regWriteNoIn = 4'd4;
        repeat (3) @(posedge clk);
        #1;
        check("mid_req_high", mem_req, 1);
        reset = 1'b1;
        set_idle();
        @(posedge clk); #1;
        check("mid_rst_req", mem_req, 0);
        check("mid_rst_stall", stall, 0);
        check("mid_rst_wb", {wbDataOut, wbRegNoOut, wbWrRegOut}, 0);
        reset = 1'b0;

`ifdef MEM_TIMEOUT_EN
        issue(32'h110, 32'h48, 32'h0, 32'h0, 4'd6, 0, 1, 2'd1, 1000);
        check("to_req", mem_req, 0);
        check("to_wb_data", wbDataOut, 32'hDEADBEEF);
`endif

        for (int i = 0; i < 300; i++) begin
            wm  = ($urandom % 4 == 0);
            wr  = 1'($urandom % 2);
            sel = 2'($urandom % 4);
            if ($urandom % 3 == 0) begin wm = 0; wr = 1; sel = 2'd1; end
            widx = $urandom % 16;
            off  = ($urandom % 4 == 0) ? $urandom_range(1, 3) : 0;
            hi   = $urandom;
            alu  = (hi & 32'hFFFF_FFC0) | 32'(widx << 2) | 32'(off);
`ifdef MEM_TIMEOUT_EN
            lat = $urandom_range(0, 5);
`else
            lat = $urandom_range(0, 4);
`endif
            issue($urandom, alu, $urandom, $urandom, 4'($urandom), wm, wr, sel, lat);
        end

        set_idle();
        repeat (4) @(posedge clk);
        #1;
        check("err_pulses", 64'(err_seen), 64'(err_exp));
        check("wb_drained", 64'(wb_q.size()), 64'd0);
        check("req_drained", 64'(req_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the pipelined processor; consumes the EX/MEM latch outputs and drives the MEM/WB register.
- Performs data-memory loads and stores over a req/ack handshake with variable latency.
- Holds the upstream pipeline with `stall` while an access is outstanding.
- Selects the writeback value and registers it, together with the destination register number and write enable, for the WB stage.

Parameters:
- DATA_BIT_WIDTH, 32, datapath width.
- ADDR_BITS, 14, data-memory word-address width.
- RESET_VALUE, 0, reset value of all registered outputs.
- TIMEOUT_CYCLES, 255, WAIT cycles before abort; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset
- pcIncrementedIn  in  DATA_BIT_WIDTH  PC+4 from EX/MEM
- aluResultIn  in  DATA_BIT_WIDTH  ALU result; byte address for memory ops
- condRegResultIn  in  DATA_BIT_WIDTH  condition-register result
- regData2In  in  DATA_BIT_WIDTH  store data
- regWriteNoIn  in  4  destination register
- wrMemIn  in  1  store request
- wrRegIn  in  1  register write enable
- dstRegMuxSelIn  in  2  writeback source select
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_BITS  word address
- mem_wdata  out  DATA_BIT_WIDTH  store data
- mem_rdata  in  DATA_BIT_WIDTH  load data; valid with mem_ack
- mem_ack  in  1  access complete
- stall  out  1  hold upstream latches and PC
- wbDataOut  out  DATA_BIT_WIDTH  writeback value
- wbRegNoOut  out  4  writeback register
- wbWrRegOut  out  1  writeback enable
- mem_err  out  1  one-cycle error pulse

Behaviour:
- Interface: reset is synchronous and active-high; the clock is clk.
- Reset values:
  - state = IDLE.
  - mem_req, mem_we, mem_err = 0.
  - mem_addr, mem_wdata, wbDataOut, wbRegNoOut, wbWrRegOut = RESET_VALUE.
- dstRegMuxSel encoding: 00 aluResult, 01 memory load, 10 pcIncremented, 11 condRegResult.
- Access classification:
  - store = wrMemIn.
  - load = wrRegIn && dstRegMuxSelIn==01 && !wrMemIn.
  - access = store || load.
- Word address = aluResultIn[ADDR_BITS+1:2]. Misaligned means aluResultIn[1:0] != 0.
- FSM states: IDLE, WAIT, DONE.
  - IDLE, access && aligned: next edge → WAIT; mem_req=1, mem_we=store, mem_addr, mem_wdata=regData2In registered.
  - IDLE, access && misaligned: no request; mem_err pulses 1 cycle at next edge; wbWrRegOut=0 for that instruction; stays IDLE.
  - IDLE, no access: writeback registered at next edge.
  - WAIT: mem_req held high; addr/we/wdata held stable until ack.
  - WAIT, mem_ack=1: mem_req=0 and rdata captured at that edge; → DONE.
  - DONE: writeback registered (load → captured rdata); → IDLE.
- stall = (IDLE && access && aligned) || WAIT. It is combinational and 0 in DONE.
- While stall=1, the MEM/WB register receives a bubble (wbWrRegOut=0; data and reg number unchanged).
- Minimum occupancy of an aligned access: 3 cycles (ack in first WAIT cycle). A non-access instruction occupies 1 cycle.
- Writeback data for non-load instructions is selected per dstRegMuxSel from the held inputs.
- A store never writes back, regardless of wrRegIn.
- mem_ack outside WAIT is ignored.
- Back-to-back accesses: a DONE→IDLE transition may immediately start the next access (no idle cycle beyond IDLE evaluation).
- Reset mid-access: the next edge returns to IDLE with mem_req=0; the pending access is discarded and no writeback occurs.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit-min counter clears on entry to WAIT and increments each WAIT cycle without ack.
  - On reaching TIMEOUT_CYCLES: mem_req drops, → DONE, load data forced to 32'hDEADBEEF, mem_err pulses 1 cycle.
  - An ack on the same cycle as the timeout wins (normal completion).
- Not defined: no counter; WAIT persists until mem_ack, and mem_err is driven only by misalignment.

Test Plan:
1. **ALU writeback:** aluResultIn=0x1234, wrRegIn=1, dstRegMuxSelIn=00, regWriteNoIn=5 → next edge wbDataOut=0x1234, wbRegNoOut=5, wbWrRegOut=1; stall never asserted.
2. **Load, slow ack:** load at aluResultIn=0x40, ack after 3 WAIT cycles with mem_rdata=0xCAFEF00D → mem_addr=0x10, mem_we=0, stall high for 4 cycles, then wbDataOut=0xCAFEF00D, wbWrRegOut=1.
3. **Store:** wrMemIn=1, aluResultIn=0x8, regData2In=0xA5A5A5A5, ack in first WAIT cycle → mem_we=1, mem_addr=2, mem_wdata=0xA5A5A5A5, stall for 2 cycles, wbWrRegOut=0.
4. **Misaligned:** load at aluResultIn=0x42 → mem_req stays 0, mem_err pulses 1 cycle, wbWrRegOut=0, stall=0.
5. **Reset mid-access:** reset asserted in WAIT → next cycle state IDLE, mem_req=0, stall=0, all wb outputs 0.
6. **Timeout (MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4):** load with no ack → after 4 WAIT cycles mem_req=0, mem_err pulse, wbDataOut=0xDEADBEEF.
